// File: rtl/main_pkg.sv
// Shared encodings for the main coprocessor: FSM state codes, mode codes and
// per-mode iteration counts.
package main_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'b000,
    ST_LOAD = 3'b001,
    ST_SQRT = 3'b010,
    ST_MUL  = 3'b011,
    ST_CBRT = 3'b100,
    ST_DONE = 3'b101
  } state_t;

  typedef enum logic [1:0] {
    MODE_OFF  = 2'b00,
    MODE_SQRT = 2'b01,
    MODE_SQH  = 2'b10,
    MODE_CBRT = 2'b11
  } mode_t;

  localparam int N_SQRT = 4;
  localparam int N_SQH  = 8;
  localparam int N_CBRT = 3;

  // Counter value on the final compute cycle of a mode.
  function automatic logic [2:0] last_iter(input mode_t m);
    case (m)
      MODE_SQRT: return 3'(N_SQRT - 1);
      MODE_SQH:  return 3'(N_SQH - 1);
      MODE_CBRT: return 3'(N_CBRT - 1);
      default:   return 3'd0;
    endcase
  endfunction

  function automatic state_t mode_state(input mode_t m);
    case (m)
      MODE_SQRT: return ST_SQRT;
      MODE_SQH:  return ST_MUL;
      MODE_CBRT: return ST_CBRT;
      default:   return ST_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/main_datapath.sv
// Iterative datapath: latched operand, accumulators, iteration counter and the
// per-mode step (restoring sqrt, shift-add square, trial-bit cube root).
module main_datapath import main_pkg::*; (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       load_op_i,
  input  logic       clear_i,
  input  logic       step_i,
  input  mode_t      mode_i,
  input  logic [7:0] x_i,
  output logic       last_o,
  output logic [7:0] res_o
);

  logic [7:0]  op_q;
  logic [7:0]  sh_q, sh_d;
  logic [7:0]  rem_q, rem_d;
  logic [7:0]  res_q, res_d;
  logic [15:0] acc_q, acc_d;
  logic [2:0]  cnt_q;

  logic [9:0]  rem_n, trial_sq;
  logic [2:0]  trial_cb;
  logic [8:0]  cube;
  logic [15:0] addend;

  always_comb begin
    sh_d     = sh_q;
    rem_d    = rem_q;
    res_d    = res_q;
    acc_d    = acc_q;
    // Remainder stays below 2*root+1, so 8 bits of carried remainder suffice.
    rem_n    = {rem_q, sh_q[7:6]};
    trial_sq = {res_q, 2'b01};
    trial_cb = res_q[2:0] | (3'b100 >> cnt_q);
    cube     = 9'(trial_cb) * 9'(trial_cb) * 9'(trial_cb);
    addend   = op_q[cnt_q] ? ({8'b0, op_q} << cnt_q) : 16'd0;
    case (mode_i)
      MODE_SQRT: begin
        sh_d = {sh_q[5:0], 2'b00};
        if (rem_n >= trial_sq) begin
          rem_d = 8'(rem_n - trial_sq);
          res_d = {res_q[6:0], 1'b1};
        end else begin
          rem_d = rem_n[7:0];
          res_d = {res_q[6:0], 1'b0};
        end
      end
      MODE_SQH:  acc_d = acc_q + addend;
      MODE_CBRT: if (cube <= {1'b0, op_q}) res_d = {5'b0, trial_cb};
      default: ;
    endcase
    res_o  = (mode_i == MODE_SQH) ? acc_d[15:8] : res_d;
    last_o = (cnt_q == last_iter(mode_i));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      op_q  <= '0;
      sh_q  <= '0;
      rem_q <= '0;
      res_q <= '0;
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      if (load_op_i) op_q <= x_i;
      if (clear_i) begin
        sh_q  <= op_q;
        rem_q <= '0;
        res_q <= '0;
        acc_q <= '0;
        cnt_q <= '0;
      end else if (step_i) begin
        sh_q  <= sh_d;
        rem_q <= rem_d;
        res_q <= res_d;
        acc_q <= acc_d;
        cnt_q <= cnt_q + 3'd1;
      end
    end
  end

endmodule

// File: rtl/main_unit.sv
// Multi-cycle 8-bit arithmetic coprocessor: control FSM and output registers
// around main_datapath. Result lands in y on the edge entering DONE.
module main_unit import main_pkg::*; #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] x,
  input  logic [1:0]   on,
  input  logic         start,
  output logic [W-1:0] y,
  output logic [2:0]   s,
  output logic         b,
  output logic [1:0]   regime,
  output logic         active
);

  state_t     state_q, state_d;
  mode_t      regime_q, regime_d;
  mode_t      on_m;
  logic [7:0] y_q, y_d;
  logic       accept, compute, dp_last;
  logic [7:0] dp_res;

  assign on_m    = mode_t'(on);
  assign accept  = (state_q == ST_IDLE) && start && (on_m != MODE_OFF);
  assign compute = (state_q == ST_SQRT) || (state_q == ST_MUL) || (state_q == ST_CBRT);

  main_datapath u_dp (
    .clk_i     (clk),
    .rst_i     (rst),
    .load_op_i (accept),
    .clear_i   (state_q == ST_LOAD),
    .step_i    (compute),
    .mode_i    (regime_q),
    .x_i       (x),
    .last_o    (dp_last),
    .res_o     (dp_res)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Dropping on to OFF aborts any busy state; a nonzero change is ignored.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_LOAD;
      ST_LOAD: state_d = (on_m == MODE_OFF) ? ST_IDLE : mode_state(regime_q);
      ST_SQRT, ST_MUL, ST_CBRT: begin
        if (on_m == MODE_OFF) state_d = ST_IDLE;
        else if (dp_last)     state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    regime_d = accept ? on_m : regime_q;
    y_d      = (compute && (on_m != MODE_OFF) && dp_last) ? dp_res : y_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y_q      <= '0;
      regime_q <= MODE_OFF;
    end else begin
      y_q      <= y_d;
      regime_q <= regime_d;
    end
  end

  always_comb begin
    s      = state_q;
    b      = (state_q == ST_LOAD) || compute;
    y      = W'(y_q);
    regime = regime_q;
    active = (on != 2'b00);
  end

endmodule

// File: tb/tb_main_unit.sv
// Self-checking bench for main_unit: directed cases plus randomized ops
// checked against an arithmetic reference model.
module tb_main_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] x;
  logic [1:0] on;
  logic       start;
  logic [7:0] y;
  logic [2:0] s;
  logic       b;
  logic [1:0] regime;
  logic       active;

  int n_checks = 0;
  int n_fail   = 0;
  int prev_y   = 0;

  main_unit #(.W(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .x      (x),
    .on     (on),
    .start  (start),
    .y      (y),
    .s      (s),
    .b      (b),
    .regime (regime),
    .active (active)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic int model(input int m, input int v);
    int r;
    r = 0;
    case (m)
      1: while ((r + 1) * (r + 1) <= v) r++;
      2: r = (v * v) / 256;
      3: while ((r + 1) * (r + 1) * (r + 1) <= v) r++;
      default: r = 0;
    endcase
    return r;
  endfunction

  // Entered and left at a negedge; walks LOAD, N compute cycles, DONE, IDLE.
  task automatic run_op(input int m, input int xv);
    int n, code, exp;
    n    = (m == 1) ? 4 : (m == 2) ? 8 : 3;
    code = (m == 1) ? 2 : (m == 2) ? 3 : 4;
    exp  = model(m, xv);
    on = 2'(m); x = 8'(xv); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    x = 8'($urandom);
    check("load_s", s, 1);
    check("load_b", b, 1);
    check("load_regime", regime, m);
    check("load_y_hold", y, prev_y);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 3) == 0) on = 2'($urandom_range(1, 3));
      @(negedge clk);
      check($sformatf("cmp%0d_s", m), s, code);
      check("cmp_b", b, 1);
      check("cmp_y_hold", y, prev_y);
    end
    @(negedge clk);
    check("done_s", s, 5);
    check("done_b", b, 0);
    check($sformatf("y m=%0d x=%0d", m, xv), y, exp);
    @(negedge clk);
    check("idle_s", s, 0);
    check("idle_y_hold", y, exp);
    prev_y = exp;
  endtask

  initial begin
    rst = 1'b1; on = 2'b01; x = 8'd0; start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("rst_y", y, 0);
    check("rst_s", s, 0);
    check("rst_b", b, 0);
    check("rst_regime", regime, 0);
    check("rst_active", active, 1);
    rst = 1'b0;
    @(negedge clk);

    run_op(1, 200);
    run_op(2, 200);
    run_op(2, 255);
    run_op(2, 0);
    run_op(3, 125);
    run_op(3, 255);
    run_op(3, 7);
    run_op(1, 255);
    run_op(1, 0);

    // Requests with mode off are ignored.
    on = 2'b00; start = 1'b1; x = 8'd99;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("off_s", s, 0);
      check("off_b", b, 0);
      check("off_y", y, prev_y);
      check("off_active", active, 0);
    end
    start = 1'b0;

    // Abort a square op mid-flight.
    on = 2'b10; x = 8'd180; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("abort_pre_s", s, 3);
    on = 2'b00;
    @(negedge clk);
    check("abort_s", s, 0);
    check("abort_b", b, 0);
    check("abort_y", y, prev_y);
    check("abort_regime", regime, 2);
    @(negedge clk);
    check("abort_stay_s", s, 0);

    // Reset in the middle of a square root.
    on = 2'b01; x = 8'd200; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("midrst_pre_s", s, 2);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_y", y, 0);
    check("midrst_s", s, 0);
    check("midrst_b", b, 0);
    check("midrst_regime", regime, 0);
    rst = 1'b0;
    prev_y = 0;
    @(negedge clk);

    for (int k = 0; k < 40; k++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        on = 2'($urandom_range(0, 3));
        start = 1'b0;
        @(negedge clk);
        check("gap_s", s, 0);
      end
      run_op($urandom_range(1, 3), $urandom_range(0, 255));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
